// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS controller: Moore sequencer with memory stall handshake, sticky illegal flag
// and retired-instruction counter. Define MCU_BNE_EN to add bne support.
module multicycle_control_unit #(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6,
  parameter int ALUC_W  = 3,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    OpCode,
  input  logic [FUNCT_W-1:0] Funct,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCEn,
  output logic [1:0]         PCSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUC_W-1:0]  ALUControl,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               illegal,
  output logic [CNT_W-1:0]   instr_cnt,
  output logic [3:0]         state
);
  // state   | meaning
  // FETCH   | read instruction at PC, PC += 4 (waits on mem_ready)
  // DECODE  | compute branch target, dispatch on opcode
  // MEMADR  | compute load/store address
  // MEMRD   | read data memory (waits on mem_ready)
  // MEMWB   | write loaded word to register file
  // MEMWR   | write data memory (waits on mem_ready)
  // EXECUTE | R-type ALU operation
  // ALUWB   | write R-type result
  // BRANCH  | compare operands, conditionally load PC
  // ADDIEX  | add immediate
  // ADDIWB  | write addi result
  // JUMP    | load PC with jump target
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  state_t           r_state;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instr_cnt;

  state_t     w_next;
  state_t     w_dec_state;
  logic       w_retire;
  logic       w_set_illegal;
  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic       w_op_hi_ok;
  logic       w_fn_hi_ok;
  logic       w_is_lw;
  logic       w_is_sw;
  logic       w_is_rtype;
  logic       w_is_branch_op;
  logic       w_is_addi;
  logic       w_is_j;
  logic       w_fn_legal;
  logic [2:0] w_aluc_funct;
  logic [2:0] w_aluc;
  logic       w_pc_write;
  logic       w_branch;

  // Only the low 6 bits are decoded; any wider upper bits must be zero.
  assign w_op       = OpCode[5:0];
  assign w_fn       = Funct[5:0];
  assign w_op_hi_ok = ((OpCode >> 6) == '0);
  assign w_fn_hi_ok = ((Funct >> 6) == '0);

  always_comb begin
    w_fn_legal   = 1'b1;
    w_aluc_funct = 3'b000;
    case (w_fn)
      6'b100000: w_aluc_funct = 3'b010;
      6'b100010: w_aluc_funct = 3'b110;
      6'b100100: w_aluc_funct = 3'b000;
      6'b100101: w_aluc_funct = 3'b001;
      6'b101010: w_aluc_funct = 3'b111;
      default:   w_fn_legal   = 1'b0;
    endcase
  end

  assign w_is_lw    = w_op_hi_ok && (w_op == 6'b100011);
  assign w_is_sw    = w_op_hi_ok && (w_op == 6'b101011);
  assign w_is_rtype = w_op_hi_ok && (w_op == 6'b000000) && w_fn_hi_ok && w_fn_legal;
  assign w_is_addi  = w_op_hi_ok && (w_op == 6'b001000);
  assign w_is_j     = w_op_hi_ok && (w_op == 6'b000010);

`ifdef MCU_BNE_EN
  logic w_is_bne;
  assign w_is_bne       = w_op_hi_ok && (w_op == 6'b000101);
  assign w_is_branch_op = (w_op_hi_ok && (w_op == 6'b000100)) || w_is_bne;
`else
  assign w_is_branch_op = w_op_hi_ok && (w_op == 6'b000100);
`endif

  always_comb begin
    w_next        = S_FETCH;
    w_retire      = 1'b0;
    w_set_illegal = 1'b0;
    case (r_state)
      S_FETCH:   w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (w_is_lw || w_is_sw)  w_next = S_MEMADR;
        else if (w_is_rtype)     w_next = S_EXECUTE;
        else if (w_is_branch_op) w_next = S_BRANCH;
        else if (w_is_addi)      w_next = S_ADDIEX;
        else if (w_is_j)         w_next = S_JUMP;
        else                     w_set_illegal = 1'b1;
      end
      S_MEMADR:  w_next = w_is_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:   w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   w_retire = 1'b1;
      S_MEMWR: begin
        w_next   = mem_ready ? S_FETCH : S_MEMWR;
        w_retire = mem_ready;
      end
      S_EXECUTE: w_next = S_ALUWB;
      S_ALUWB:   w_retire = 1'b1;
      S_BRANCH:  w_retire = 1'b1;
      S_ADDIEX:  w_next = S_ADDIWB;
      S_ADDIWB:  w_retire = 1'b1;
      S_JUMP:    w_retire = 1'b1;
      default:   w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_illegal   <= 1'b0;
      r_instr_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_retire)      r_instr_cnt <= r_instr_cnt + CNT_W'(1);
    end
  end

  // Reset forces the FETCH decode so the datapath sees a clean fetch while rst is held.
  assign w_dec_state = rst ? S_FETCH : r_state;

  always_comb begin
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCSrc      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    w_aluc     = 3'b000;
    w_pc_write = 1'b0;
    w_branch   = 1'b0;
    case (w_dec_state)
      S_FETCH: begin
        ALUSrcB    = 2'b01;
        w_aluc     = 3'b010;
        IRWrite    = mem_ready;
        w_pc_write = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        w_aluc  = 3'b010;
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_aluc  = 3'b010;
      end
      S_MEMRD:   IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        w_aluc  = w_aluc_funct;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        w_aluc   = 3'b110;
        w_branch = 1'b1;
        PCSrc    = 2'b01;
      end
      S_ADDIWB:  RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc      = 2'b10;
        w_pc_write = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MCU_BNE_EN
  assign PCEn = w_pc_write | (w_branch & (Zero ^ w_is_bne));
`else
  assign PCEn = w_pc_write | (w_branch & Zero);
`endif

  assign ALUControl = ALUC_W'(w_aluc);
  assign illegal    = r_illegal;
  assign instr_cnt  = r_instr_cnt;
  assign state      = r_state;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: instruction-level model predicts every cycle's
// state and control word; a negedge monitor pops and compares.
module tb_multicycle_control_unit;
`ifdef MCU_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [5:0]  OpCode;
  logic [5:0]  Funct;
  logic        Zero;
  logic        mem_ready;
  logic        IorD, MemWrite, IRWrite, PCEn;
  logic [1:0]  PCSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUControl;
  logic        RegWrite, RegDst, MemtoReg, illegal;
  logic [31:0] instr_cnt;
  logic [3:0]  state;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCEn(PCEn), .PCSrc(PCSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .illegal(illegal), .instr_cnt(instr_cnt), .state(state)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic        iord, memw, irw, pcen;
    logic [1:0]  pcsrc;
    logic        srca;
    logic [1:0]  srcb;
    logic [2:0]  aluc;
    logic        regw, regdst, m2r, ill;
    logic [31:0] cnt;
  } rec_t;

  rec_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic        m_ill = 1'b0;
  logic [31:0] m_cnt = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit fn_ok(logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic logic [2:0] fmap(logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

  // Expected control word for a cycle; reset shows the FETCH word but the current state/flags.
  function automatic rec_t exp_rec(int st, logic mr, logic z, logic r, logic [5:0] op,
                                   logic [5:0] fn, logic ill, logic [31:0] cnt);
    rec_t e;
    int   ds;
    e     = '0;
    e.st  = 4'(st);
    e.ill = ill;
    e.cnt = cnt;
    ds    = r ? 0 : st;
    case (ds)
      0:  begin e.srcb = 2'b01; e.aluc = 3'b010; e.irw = mr; e.pcen = mr; end
      1:  begin e.srcb = 2'b11; e.aluc = 3'b010; end
      2:  begin e.srca = 1'b1; e.srcb = 2'b10; e.aluc = 3'b010; end
      3:  e.iord = 1'b1;
      4:  begin e.m2r = 1'b1; e.regw = 1'b1; end
      5:  begin e.iord = 1'b1; e.memw = 1'b1; end
      6:  begin e.srca = 1'b1; e.aluc = fmap(fn); end
      7:  begin e.regdst = 1'b1; e.regw = 1'b1; end
      8:  begin e.srca = 1'b1; e.aluc = 3'b110; e.pcsrc = 2'b01;
                e.pcen = z ^ (BNE_EN && op == 6'b000101); end
      9:  begin e.srca = 1'b1; e.srcb = 2'b10; e.aluc = 3'b010; end
      10: e.regw = 1'b1;
      11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      rec_t e, a;
      e = sb.pop_front();
      a = {state, IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB, ALUControl,
           RegWrite, RegDst, MemtoReg, illegal, instr_cnt};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL ctl cyc=%0d got=%h want=%h (st got=%0d want=%0d cnt got=%0d want=%0d)",
                 cyc, a, e, a.st, e.st, a.cnt, e.cnt);
      end
    end
  end

  task automatic cycle(input int st, input logic mr, input logic r);
    rst       = r;
    mem_ready = mr;
    sb.push_back(exp_rec(st, mr, Zero, r, OpCode, Funct, m_ill, m_cnt));
    @(posedge clk);
    #1;
    if (r) begin
      m_cnt = '0;
      m_ill = 1'b0;
    end
  endtask

  // Expands one instruction into its state sequence, with stall cycles in memory-wait states.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int st_f,
                           input int st_m, input logic z);
    int   seq[$];
    bit   legal;
    int   n;
    logic mr;
    OpCode = op;
    Funct  = fn;
    Zero   = z;
    legal  = 1'b1;
    if (op == 6'b100011)                              seq = '{0, 1, 2, 3, 4};
    else if (op == 6'b101011)                         seq = '{0, 1, 2, 5};
    else if (op == 6'b000000 && fn_ok(fn))            seq = '{0, 1, 6, 7};
    else if (op == 6'b000100 || (BNE_EN && op == 6'b000101)) seq = '{0, 1, 8};
    else if (op == 6'b001000)                         seq = '{0, 1, 9, 10};
    else if (op == 6'b000010)                         seq = '{0, 1, 11};
    else begin
      seq   = '{0, 1};
      legal = 1'b0;
    end
    foreach (seq[i]) begin
      bit waits;
      waits = (seq[i] == 0) || (seq[i] == 3) || (seq[i] == 5);
      n = (seq[i] == 0) ? st_f : waits ? st_m : 0;
      for (int k = 0; k <= n; k++) begin
        if (waits) mr = (k == n);
        else       mr = 1'($urandom_range(0, 1));
        cycle(seq[i], mr, 1'b0);
      end
    end
    if (legal) m_cnt = m_cnt + 32'd1;
    else       m_ill = 1'b1;
  endtask

  initial begin
    logic [5:0] fl [5];
    logic [5:0] op, fn;
    int         k;
    fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    rst = 1'b1; mem_ready = 1'b0; OpCode = '0; Funct = '0; Zero = 1'b0;
    @(posedge clk);
    #1;
    cycle(0, 1'b0, 1'b1);
    cycle(0, 1'b1, 1'b1);

    // directed cases
    run_instr(6'b000000, 6'b100000, 0, 0, 1'b0);  // add
    run_instr(6'b100011, 6'b000000, 0, 2, 1'b0);  // lw, 2-cycle MEMRD stall
    run_instr(6'b000100, 6'b000000, 1, 0, 1'b1);  // beq taken
    run_instr(6'b000100, 6'b000000, 0, 0, 1'b0);  // beq not taken
    run_instr(6'b111111, 6'b000000, 0, 0, 1'b0);  // illegal opcode
    run_instr(6'b001000, 6'b000000, 0, 0, 1'b0);  // addi, illegal stays set
    run_instr(6'b000000, 6'b110011, 0, 0, 1'b0);  // illegal funct
    run_instr(6'b000101, 6'b000000, 0, 0, 1'b0);  // bne (or illegal)
    run_instr(6'b000101, 6'b000000, 0, 0, 1'b1);
    run_instr(6'b000010, 6'b000000, 2, 0, 1'b0);  // j

    // reset while sw is stalled in MEMWR
    OpCode = 6'b101011; Funct = '0; Zero = 1'b0;
    cycle(0, 1'b1, 1'b0);
    cycle(1, 1'b1, 1'b0);
    cycle(2, 1'b1, 1'b0);
    cycle(5, 1'b0, 1'b0);
    cycle(5, 1'b0, 1'b0);
    cycle(5, 1'b0, 1'b1);
    run_instr(6'b101011, 6'b000000, 0, 1, 1'b0);

    for (int t = 0; t < 300; t++) begin
      k  = $urandom_range(0, 8);
      fn = 6'($urandom);
      case (k)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: begin op = 6'b000000; fn = fl[$urandom_range(0, 4)]; end
        3: op = 6'b000100;
        4: op = 6'b001000;
        5: op = 6'b000010;
        6: op = 6'b000101;
        7: op = 6'b000000;
        default: op = 6'($urandom);
      endcase
      run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
